// File: rtl/water_supply_valve_fsm_if.sv
// Probe/valve signal bundle between the tank-side driver and the valve controller.
interface water_supply_valve_fsm_if #(
    parameter int unsigned VALVE_WIDTH = 4
);
    logic                   enable;
    logic                   low_water_level;
    logic                   high_water_level;
    logic                   fault_ack;
    logic [VALVE_WIDTH-1:0] valvule;
    logic                   valve_open;
    logic                   fault;
    logic [1:0]             fault_code;
    logic [1:0]             state;

    modport master (
        output enable, low_water_level, high_water_level, fault_ack,
        input  valvule, valve_open, fault, fault_code, state
    );

    modport slave (
        input  enable, low_water_level, high_water_level, fault_ack,
        output valvule, valve_open, fault, fault_code, state
    );
endinterface

// File: rtl/water_supply_valve_fsm.sv
// Hysteretic tank fill controller: debounced probes, closed dwell, fill timeout
// and latched conflict/timeout faults that hold the valve closed.
module water_supply_valve_fsm #(
    parameter int unsigned VALVE_WIDTH       = 4,
    parameter int unsigned DEBOUNCE_CYCLES   = 4,
    parameter int unsigned MIN_CLOSED_CYCLES = 8,
    parameter int unsigned MAX_FILL_CYCLES   = 64,
    parameter int unsigned LOCKOUT_CYCLES    = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    water_supply_valve_fsm_if.slave  bus
);
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned DW_W = $clog2(MIN_CLOSED_CYCLES + 1);
    localparam int unsigned FL_W = $clog2(MAX_FILL_CYCLES + 1);
    localparam int unsigned CL_W = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [1:0] ST_CLOSED  = 2'b00;
    localparam logic [1:0] ST_FILLING = 2'b01;
    localparam logic [1:0] ST_FAULT   = 2'b10;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_CONFLICT = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;

    localparam logic [VALVE_WIDTH-1:0] VALVE_CLOSED = '1;
    localparam logic [VALVE_WIDTH-1:0] VALVE_OPEN   = ~VALVE_WIDTH'(1);

    // Probe index 0 = low, 1 = high.
    logic [1:0]      raw;
    logic [1:0]      filt_q;
    logic [DB_W-1:0] db_cnt_q [2];
    logic            low_f;
    logic            high_f;
    logic            conflict_f;

    logic [1:0]             state_q, state_d;
    logic [1:0]             code_q, code_d;
    logic [DW_W-1:0]        dwell_q, dwell_d;
    logic [FL_W-1:0]        fill_q, fill_d;
    logic [CL_W-1:0]        clear_q, clear_d;
    logic [VALVE_WIDTH-1:0] valvule_q;
    logic                   valve_open_q;
    logic                   fault_q;

    assign raw        = {bus.high_water_level, bus.low_water_level};
    assign low_f      = filt_q[0];
    assign high_f     = filt_q[1];
    assign conflict_f = high_f & ~low_f;

    // Filtered bit follows raw only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filt_q <= 2'b01;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == filt_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    filt_q[i]   <= raw[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Next state; conflict outranks timeout, which outranks a normal close.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        dwell_d = dwell_q;
        fill_d  = fill_q;
        clear_d = clear_q;
        case (state_q)
            ST_CLOSED: begin
                if (dwell_q < DW_W'(MIN_CLOSED_CYCLES)) dwell_d = dwell_q + DW_W'(1);
                if (conflict_f) begin
                    state_d = ST_FAULT;
                    code_d  = FC_CONFLICT;
                    clear_d = '0;
                end else if (bus.enable && !low_f && (dwell_q >= DW_W'(MIN_CLOSED_CYCLES))) begin
                    state_d = ST_FILLING;
                    fill_d  = '0;
                end
            end
            ST_FILLING: begin
                fill_d = fill_q + FL_W'(1);
                if (conflict_f) begin
                    state_d = ST_FAULT;
                    code_d  = FC_CONFLICT;
                    clear_d = '0;
                end else if (fill_q == FL_W'(MAX_FILL_CYCLES - 1)) begin
                    state_d = ST_FAULT;
                    code_d  = FC_TIMEOUT;
                end else if (high_f || !bus.enable) begin
                    state_d = ST_CLOSED;
                    dwell_d = '0;
                end
            end
            ST_FAULT: begin
                if (conflict_f) begin
                    code_d  = FC_CONFLICT;
                    clear_d = '0;
                end else if (code_q == FC_TIMEOUT) begin
                    if (bus.fault_ack) begin
                        state_d = ST_CLOSED;
                        code_d  = FC_NONE;
                        dwell_d = '0;
                    end
                end else if (clear_q == CL_W'(LOCKOUT_CYCLES - 1)) begin
                    state_d = ST_CLOSED;
                    code_d  = FC_NONE;
                    dwell_d = '0;
                    clear_d = '0;
                end else begin
                    clear_d = clear_q + CL_W'(1);
                end
            end
            default: begin
                state_d = ST_CLOSED;
                code_d  = FC_NONE;
                dwell_d = '0;
            end
        endcase
    end

    // Output flops are loaded from the next state so they track the registered state exactly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_CLOSED;
            code_q       <= FC_NONE;
            dwell_q      <= '0;
            fill_q       <= '0;
            clear_q      <= '0;
            valvule_q    <= VALVE_CLOSED;
            valve_open_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            dwell_q      <= dwell_d;
            fill_q       <= fill_d;
            clear_q      <= clear_d;
            valvule_q    <= (state_d == ST_FILLING) ? VALVE_OPEN : VALVE_CLOSED;
            valve_open_q <= (state_d == ST_FILLING);
            fault_q      <= (state_d == ST_FAULT);
        end
    end

    assign bus.valvule    = valvule_q;
    assign bus.valve_open = valve_open_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_water_supply_valve_fsm.sv
// Directed bench for the valve controller: stimulus queues expected states per edge,
// a negedge monitor pops and compares them.
module tb_water_supply_valve_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    typedef struct packed {
        logic [31:0] at;
        logic [1:0]  st;
        logic [1:0]  code;
        logic [3:0]  valv;
        logic        open;
        logic        flt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mon_e;
    string mon_n;

    water_supply_valve_fsm_if #(.VALVE_WIDTH(4)) bus ();

    water_supply_valve_fsm dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [1:0] CL = 2'b00, FI = 2'b01, FA = 2'b10;

    task automatic expect_at(input int k, input string nm, input logic [1:0] st, input logic [1:0] code);
        exp_t e;
        e.at   = 32'(cyc + k);
        e.st   = st;
        e.code = code;
        e.valv = (st == FI) ? 4'b1110 : 4'b1111;
        e.open = (st == FI);
        e.flt  = (st == FA);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic lo, input logic hi, input logic ack);
        bus.enable           = en;
        bus.low_water_level  = lo;
        bus.high_water_level = hi;
        bus.fault_ack        = ack;
    endtask

    // Monitor: every queued expectation is compared on the negedge of its edge.
    always @(negedge clk) begin
        while (exp_q.size() != 0 && int'(exp_q[0].at) <= cyc) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            checks++;
            if (int'(mon_e.at) != cyc)
                $display("FAIL %s: expectation for edge %0d not evaluated (now %0d)", mon_n, mon_e.at, cyc);
            else if ({bus.state, bus.fault_code, bus.valvule, bus.valve_open, bus.fault} ==
                     {mon_e.st, mon_e.code, mon_e.valv, mon_e.open, mon_e.flt})
                passed++;
            else
                $display("FAIL %s @%0d: got st=%b code=%b valv=%b open=%b flt=%b, want st=%b code=%b valv=%b open=%b flt=%b",
                         mon_n, cyc, bus.state, bus.fault_code, bus.valvule, bus.valve_open, bus.fault,
                         mon_e.st, mon_e.code, mon_e.valv, mon_e.open, mon_e.flt);
        end
    end

    initial begin
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        edges(2);
        expect_at(0, "reset_state", CL, 2'b00);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(8, "no_open_before_dwell", CL, 2'b00);
        expect_at(9, "first_open_edge9", FI, 2'b00);
        edges(9);

        // Full tank closes after debounce + 1 edges; reopen waits for the dwell.
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        expect_at(4, "fill_until_high_filtered", FI, 2'b00);
        expect_at(5, "close_on_high", CL, 2'b00);
        edges(5);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(8, "dwell_blocks_reopen", CL, 2'b00);
        expect_at(9, "reopen_after_dwell", FI, 2'b00);
        edges(9);

        // Fill timeout after exactly 64 open cycles, cleared by fault_ack.
        expect_at(63, "open_63_cycles", FI, 2'b00);
        expect_at(64, "fill_timeout", FA, 2'b10);
        edges(64);
        expect_at(2, "timeout_latched", FA, 2'b10);
        edges(2);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        expect_at(1, "ack_clears_timeout", CL, 2'b00);
        edges(1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Probe conflict, lockout, and lockout restart on a 4-cycle conflict glitch.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        expect_at(4, "conflict_pending_debounce", CL, 2'b00);
        expect_at(5, "conflict_fault", FA, 2'b01);
        edges(5);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        expect_at(10, "lockout_in_progress", FA, 2'b01);
        edges(10);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        edges(4);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        expect_at(6, "lockout_restarted", FA, 2'b01);
        expect_at(19, "lockout_last_cycle", FA, 2'b01);
        expect_at(20, "lockout_release", CL, 2'b00);
        edges(20);

        // Short low glitch is filtered; between-probe water holds; enable drop closes.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        edges(6);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(3, "glitch_in_progress", CL, 2'b00);
        edges(3);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        expect_at(5, "glitch_filtered", CL, 2'b00);
        edges(5);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(4, "open_pending_debounce", CL, 2'b00);
        expect_at(5, "open_after_dry", FI, 2'b00);
        edges(5);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        expect_at(6, "hysteresis_hold_open", FI, 2'b00);
        edges(6);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        expect_at(1, "enable_drop_closes", CL, 2'b00);
        edges(1);

        // Reset mid-fill clears everything; reopen timing restarts from scratch.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(9, "refill", FI, 2'b00);
        edges(9);
        expect_at(3, "still_filling", FI, 2'b00);
        edges(3);
        rst = 1'b1;
        expect_at(1, "reset_mid_fill", CL, 2'b00);
        edges(1);
        rst = 1'b0;
        expect_at(8, "post_reset_dwell", CL, 2'b00);
        expect_at(9, "post_reset_open", FI, 2'b00);
        edges(9);

        // Timeout and high arriving together resolve to the timeout fault.
        expect_at(59, "long_fill", FI, 2'b00);
        edges(59);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        expect_at(4, "high_and_timeout_pending", FI, 2'b00);
        expect_at(5, "timeout_beats_high", FA, 2'b10);
        edges(5);
        // Conflict inside a timeout fault escalates to the conflict code; ack ignored there.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        expect_at(5, "timeout_to_conflict", FA, 2'b01);
        edges(5);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        expect_at(19, "ack_ignored_in_lockout", FA, 2'b01);
        expect_at(20, "lockout_release_2", CL, 2'b00);
        edges(20);
        drive(1'b0, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/water_supply_valve_fsm.md
# water_supply_valve_fsm

Parametrised, stateful successor to the water-supply valve controller. It debounces the low and high level probes and detects probe conflicts internally. It runs a hysteretic fill cycle with a minimum closed dwell and a fill timeout, and latches faults that hold the valve closed. It sits between the tank level probes and the valve driver; the valve code keeps the existing convention: all ones means closed, all ones with bit 0 cleared means open.

## Interface
- VALVE_WIDTH, 4: width of the valve drive code (≥1).
- DEBOUNCE_CYCLES, 4: consecutive differing samples needed before a filtered probe value changes (≥1).
- MIN_CLOSED_CYCLES, 8: minimum cycles in CLOSED before the valve may reopen (≥1).
- MAX_FILL_CYCLES, 64: maximum cycles in FILLING before a timeout fault (≥2).
- LOCKOUT_CYCLES, 16: conflict-free cycles required to leave a conflict fault (≥1).
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  fill permission; 0 forces CLOSED from FILLING.
- low_water_level  input  1  raw low probe; 1 = water at or above the low probe.
- high_water_level  input  1  raw high probe; 1 = water at or above the high probe.
- fault_ack  input  1  clears a latched timeout fault.
- valvule  output  VALVE_WIDTH  valve code: closed = all ones; open = all ones except bit 0 = 0.
- valve_open  output  1  1 only in FILLING.
- fault  output  1  1 only in FAULT.
- fault_code  output  2  00 none, 01 probe conflict, 10 fill timeout.
- state  output  2  00 CLOSED, 01 FILLING, 10 FAULT.

## Operation
- Debounce, per probe: the filter holds a filtered bit and a counter of width clog2(DEBOUNCE_CYCLES+1).
  - On each edge, if raw equals filtered, the counter is cleared.
  - Otherwise the counter increments. When the increment reaches DEBOUNCE_CYCLES, the filtered bit takes the raw value and the counter clears.
- Conflict: conflict_f = high_f & ~low_f, computed from the filtered values only.
- FSM transitions, evaluated in priority order (conflict > timeout > normal close):
  - CLOSED → FAULT(01) if conflict_f.
  - CLOSED → FILLING if enable & ~low_f & dwell_cnt ≥ MIN_CLOSED_CYCLES.
  - FILLING → FAULT(01) if conflict_f.
  - FILLING → FAULT(10) if fill_cnt == MAX_FILL_CYCLES-1.
  - FILLING → CLOSED if high_f | ~enable. Closing is never delayed.
  - FAULT(01) → CLOSED once clear_cnt reaches LOCKOUT_CYCLES. clear_cnt counts consecutive cycles with ~conflict_f and resets to 0 on any conflict.
  - FAULT(10) → CLOSED on an edge with fault_ack=1 and ~conflict_f. If conflict_f is set in FAULT(10), fault_code changes to 01 and the lockout rules apply.
  - fault_ack has no effect in any other state.
- Counters:
  - dwell_cnt clears on entry to CLOSED, then increments and saturates at MIN_CLOSED_CYCLES.
  - fill_cnt clears on entry to FILLING, then increments. The valve is therefore open for at most MAX_FILL_CYCLES cycles.
- Outputs are a Moore decode of the registered state and fault_code. valvule is the closed code in both CLOSED and FAULT.
- Hysteresis: the valve opens only when the low probe is dry and closes only on the high probe. Water between the probes (low=1, high=0) holds the current state.

## Timing
- Reset values:
  - state=CLOSED, fault_code=00, valvule=all ones, valve_open=0, fault=0.
  - low_f=1, high_f=0, all debounce counters 0, dwell_cnt=0, fill_cnt=0, clear_cnt=0.
- Probe-to-filter latency: a raw change stable from edge 1 appears in the filtered value after edge DEBOUNCE_CYCLES.
- Filter-to-state latency: the state reacts on the next edge. Total probe-to-valve latency is DEBOUNCE_CYCLES+1 edges.
- A glitch shorter than DEBOUNCE_CYCLES samples never changes the filtered value.
- enable and fault_ack are not debounced; they act on the first edge they are sampled.
- After reset, the earliest open is at edge max(MIN_CLOSED_CYCLES, DEBOUNCE_CYCLES)+1.
- Reset asserted in any state returns to the reset values at that edge, including mid-fill and mid-lockout.
- Simultaneous events resolve by the FSM priority: for example, conflict and high together in FILLING go to FAULT(01), and timeout and high together go to FAULT(10).

## Test plan
- Reset, then low=0, high=0, enable=1 held → FILLING entered at edge 9; valvule=4'b1110, valve_open=1.
- From FILLING, high=1 and low=1 held → CLOSED 5 edges later, valvule=4'b1111. Then low=0 and high=0 immediately → no reopen until dwell_cnt reaches 8.
- From FILLING, high held 0 throughout → FAULT with fault_code=10 after exactly 64 open cycles. fault_ack=1 → CLOSED at the next edge.
- high=1 and low=0 held → FAULT(01) after 5 edges. Restore consistent probes → CLOSED 4+16 edges after the probes restore. A conflict glitch of 4 or more cycles during lockout restarts clear_cnt.
- A 3-cycle low=0 glitch while CLOSED → filtered value unchanged, no open. Deassert enable in FILLING → CLOSED at the next edge.
- Reset asserted mid-FILLING → valvule=4'b1111 and state=00 at that edge, and all counters cleared.
